// File: rtl/mod_exp_ctrl.sv
// Montgomery modular exponentiation sequencer (square-and-multiply, MSB first)
// driving an external Montgomery multiplier through a registered go/done handshake.
module mod_exp_ctrl #(
   parameter int BITS = 128
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [BITS-1:0] msg,
   input  logic [BITS-1:0] exp,
   input  logic [BITS-1:0] modulus,
   input  logic [BITS-1:0] r2,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [BITS-1:0] result,
   output logic [BITS-1:0] mm_a,
   output logic [BITS-1:0] mm_b,
   output logic [BITS-1:0] mm_m,
   output logic            mm_go,
   input  logic            mm_done,
   input  logic [BITS-1:0] mm_s
);

   localparam int IW = $clog2(BITS);
   localparam logic [BITS-1:0] ONE = BITS'(1);

   typedef enum logic [2:0] {
      IDLE, MONT_M, MONT_X, SQUARE, MULT, FROM_MONT, FINISH
   } state_t;

   typedef enum logic {GAP, RUN} sub_t;

   state_t          state_q, state_d;
   sub_t            sub_q, sub_d;
   logic            gap_q, gap_d;
   logic            first_q, first_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [BITS-1:0] e_q, e_d;
   logic [BITS-1:0] r2_q, r2_d;
   logic [BITS-1:0] mb_q, mb_d;
   logic [BITS-1:0] x_q, x_d;
   logic [BITS-1:0] res_q, res_d;
   logic [BITS-1:0] a_q, a_d;
   logic [BITS-1:0] b_q, b_d;
   logic [BITS-1:0] m_q, m_d;
   logic            go_q, go_d;
   logic            err_q, err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sub_q   <= GAP;
         gap_q   <= 1'b0;
         first_q <= 1'b0;
         idx_q   <= '0;
         e_q     <= '0;
         r2_q    <= '0;
         mb_q    <= '0;
         x_q     <= '0;
         res_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         go_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         gap_q   <= gap_d;
         first_q <= first_d;
         idx_q   <= idx_d;
         e_q     <= e_d;
         r2_q    <= r2_d;
         mb_q    <= mb_d;
         x_q     <= x_d;
         res_q   <= res_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         go_q    <= go_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      gap_d   = gap_q;
      first_d = first_q;
      idx_d   = idx_q;
      e_d     = e_q;
      r2_d    = r2_q;
      mb_d    = mb_q;
      x_d     = x_q;
      res_d   = res_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      go_d    = go_q;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (modulus[0] && (msg < modulus)) begin
                  state_d = MONT_M;
                  sub_d   = GAP;
                  gap_d   = 1'b0;
                  e_d     = exp;
                  r2_d    = r2;
                  m_d     = modulus;
                  idx_d   = IW'(BITS - 1);
                  a_d     = msg;
                  b_d     = r2;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         MONT_M, MONT_X, SQUARE, MULT, FROM_MONT: begin
            unique case (sub_q)
               GAP: begin
                  if (gap_q) begin
                     sub_d   = RUN;
                     gap_d   = 1'b0;
                     go_d    = 1'b1;
                     first_d = 1'b1;
                  end else begin
                     gap_d = 1'b1;
                  end
               end
               RUN: begin
                  first_d = 1'b0;
                  // Operands for the next phase are loaded on the capture edge
                  if (!first_q && mm_done) begin
                     go_d  = 1'b0;
                     sub_d = GAP;
                     gap_d = 1'b0;
                     unique case (state_q)
                        MONT_M: begin
                           mb_d    = mm_s;
                           state_d = MONT_X;
                           a_d     = ONE;
                           b_d     = r2_q;
                        end
                        MONT_X: begin
                           x_d     = mm_s;
                           state_d = SQUARE;
                           a_d     = mm_s;
                           b_d     = mm_s;
                        end
                        SQUARE: begin
                           x_d = mm_s;
                           if (e_q[idx_q]) begin
                              state_d = MULT;
                              a_d     = mm_s;
                              b_d     = mb_q;
                           end else if (idx_q == '0) begin
                              state_d = FROM_MONT;
                              a_d     = mm_s;
                              b_d     = ONE;
                           end else begin
                              idx_d   = idx_q - IW'(1);
                              state_d = SQUARE;
                              a_d     = mm_s;
                              b_d     = mm_s;
                           end
                        end
                        MULT: begin
                           x_d = mm_s;
                           if (idx_q == '0) begin
                              state_d = FROM_MONT;
                              a_d     = mm_s;
                              b_d     = ONE;
                           end else begin
                              idx_d   = idx_q - IW'(1);
                              state_d = SQUARE;
                              a_d     = mm_s;
                              b_d     = mm_s;
                           end
                        end
                        FROM_MONT: begin
                           res_d   = mm_s;
                           state_d = FINISH;
                        end
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q != IDLE) && (state_q != FINISH);
   assign done   = (state_q == FINISH);
   assign err    = err_q;
   assign result = res_q;
   assign mm_a   = a_q;
   assign mm_b   = b_q;
   assign mm_m   = m_q;
   assign mm_go  = go_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery multiplier plus a plain
// modular-power reference, directed corner cases and random 128-bit runs.
module tb_mod_exp_ctrl;

   localparam int BITS = 128;
   typedef logic [BITS-1:0] w_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   w_t   msg = '0, exp = '0, modulus = '0, r2 = '0;
   logic busy, done, err, mm_go;
   w_t   result, mm_a, mm_b, mm_m;
   logic mm_done = 1'b0;
   w_t   mm_s = '0;

   int nassert = 0;
   int nfail   = 0;
   int rises   = 0;
   w_t cur_n   = '0;

   mod_exp_ctrl #(.BITS(BITS)) dut (
      .clk(clk), .rst(rst), .start(start),
      .msg(msg), .exp(exp), .modulus(modulus), .r2(r2),
      .busy(busy), .done(done), .err(err), .result(result),
      .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_go(mm_go),
      .mm_done(mm_done), .mm_s(mm_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input w_t obs, input w_t expv);
      nassert++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic w_t rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic w_t mulmod(input w_t a, input w_t b, input w_t n);
      logic [2*BITS-1:0] p;
      logic [2*BITS-1:0] q;
      p = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
      q = p % {{BITS{1'b0}}, n};
      return q[BITS-1:0];
   endfunction

   function automatic w_t powmod(input w_t m, input w_t e, input w_t n);
      w_t r;
      r = (n == 1) ? '0 : w_t'(1);
      for (int k = BITS - 1; k >= 0; k--) begin
         r = mulmod(r, r, n);
         if (e[k]) r = mulmod(r, m, n);
      end
      return r;
   endfunction

   function automatic w_t calc_r2(input w_t n);
      logic [2*BITS:0] t;
      t = (2*BITS+1)'(1) << (2*BITS);
      t = t % {{(BITS+1){1'b0}}, n};
      return t[BITS-1:0];
   endfunction

   // a*b*2^-BITS mod n, bit-serial
   function automatic w_t mont(input w_t a, input w_t b, input w_t n);
      logic [BITS+1:0] s;
      s = '0;
      for (int k = 0; k < BITS; k++) begin
         if (a[k]) s = s + {2'b0, b};
         if (s[0]) s = s + {2'b0, n};
         s = s >> 1;
      end
      if (s >= {2'b0, n}) s = s - {2'b0, n};
      return s[BITS-1:0];
   endfunction

   int run_cnt = 0;
   int lat = 2;
   always @(negedge clk) begin
      if (mm_go) begin
         run_cnt++;
         if (run_cnt == 1) begin
            if ($urandom_range(0, 31) == 0) lat = 30;
            else if ($urandom_range(0, 3) == 0) lat = $urandom_range(3, 4);
            else lat = 2;
            mm_done = ($urandom_range(0, 3) == 0);
            mm_s = rnd();
         end else if (run_cnt == lat) begin
            mm_done = 1'b1;
            mm_s = mont(mm_a, mm_b, mm_m);
         end else begin
            mm_done = 1'b0;
            mm_s = rnd();
         end
      end else begin
         run_cnt = 0;
         mm_done = 1'b0;
      end
   end

   logic prev_go = 1'b0;
   int   low_cnt = 100;
   w_t   pa = '0, pb = '0, pm = '0, ha = '0, hb = '0, hm = '0;
   logic stable_ok = 1'b1;
   always @(negedge clk) begin
      if (mm_go && !prev_go) begin
         rises++;
         chk("gap_len_ok", w_t'(low_cnt >= 2), w_t'(1));
         chk("ops_stable_in_gap", {mm_a ^ pa} | {mm_b ^ pb} | {mm_m ^ pm}, '0);
         chk("mm_m_is_n", mm_m, cur_n);
         ha = mm_a; hb = mm_b; hm = mm_m;
         stable_ok = 1'b1;
      end else if (mm_go && prev_go) begin
         if (mm_a !== ha || mm_b !== hb || mm_m !== hm) stable_ok = 1'b0;
      end else if (!mm_go && prev_go) begin
         chk("ops_stable_in_run", w_t'(stable_ok), w_t'(1));
      end
      low_cnt = mm_go ? 0 : low_cnt + 1;
      prev_go = mm_go;
      pa = mm_a; pb = mm_b; pm = mm_m;
   end

   task automatic do_run(input w_t n, input w_t r, input w_t m, input w_t e,
                         input bit poke, output w_t res);
      bit got;
      int errs;
      @(negedge clk);
      modulus = n; r2 = r; msg = m; exp = e; start = 1'b1;
      cur_n = n; rises = 0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", w_t'(busy), w_t'(1));
      got = 1'b0;
      errs = 0;
      for (int c = 0; c < 30000 && !got; c++) begin
         if (poke && c == 40) begin
            start = 1'b1; msg = ~m; modulus = n + 2; exp = ~e; r2 = rnd();
         end
         if (poke && c == 41) start = 1'b0;
         @(negedge clk);
         if (err) errs++;
         if (done) got = 1'b1;
      end
      chk("done_seen", w_t'(got), w_t'(1));
      chk("busy_low_at_done", w_t'(busy), w_t'(0));
      res = result;
      chk("no_err_while_busy", w_t'(errs), w_t'(0));
      chk("op_count", w_t'(rises), w_t'(131 + $countones(e)));
      @(negedge clk);
      chk("done_one_cycle", w_t'(done), w_t'(0));
      chk("result_held", result, res);
   endtask

   task automatic do_reject(input w_t n, input w_t m, input w_t prior);
      @(negedge clk);
      modulus = n; msg = m; exp = 5; r2 = 3; start = 1'b1;
      rises = 0;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", w_t'(err), w_t'(1));
      chk("rej_busy", w_t'(busy), w_t'(0));
      @(negedge clk);
      chk("err_one_cycle", w_t'(err), w_t'(0));
      repeat (4) @(negedge clk);
      chk("rej_no_go", w_t'(rises), w_t'(0));
      chk("rej_result", result, prior);
   endtask

   initial begin
      w_t res, n, m, e, r;
      bit hit;
      #23;
      chk("rst_busy", w_t'(busy), w_t'(0));
      chk("rst_done", w_t'(done), w_t'(0));
      chk("rst_err", w_t'(err), w_t'(0));
      chk("rst_go", w_t'(mm_go), w_t'(0));
      chk("rst_result", result, '0);
      chk("rst_ops", mm_a | mm_b | mm_m, '0);
      @(negedge clk);
      rst = 1'b0;

      do_run(13, 3, 2, 5, 1'b1, res);
      chk("m2_e5_n13", res, 6);
      do_reject(12, 2, 6);
      do_reject(13, 13, 6);
      do_run(13, 3, 7, 0, 1'b0, res);
      chk("e0_n13", res, 1);
      do_run(1, 0, 0, 0, 1'b0, res);
      chk("e0_n1", res, 0);
      e = rnd() | 1;
      do_run(13, 3, 0, e, 1'b0, res);
      chk("msg0", res, 0);

      @(negedge clk);
      modulus = 13; r2 = 3; msg = 2; exp = 5; start = 1'b1;
      cur_n = 13; rises = 0;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 5000 && !hit; c++) begin
         @(negedge clk);
         if (rises >= 10 && mm_go) hit = 1'b1;
      end
      chk("reached_square", w_t'(hit), w_t'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", w_t'(busy), w_t'(0));
      chk("mid_rst_go", w_t'(mm_go), w_t'(0));
      chk("mid_rst_result", result, '0);
      chk("mid_rst_ops", mm_a | mm_b | mm_m, '0);
      @(negedge clk);
      rst = 1'b0;
      do_run(13, 3, 2, 5, 1'b0, res);
      chk("after_rst", res, 6);

      for (int k = 0; k < 50; k++) begin
         n = rnd() | 1;
         if (k % 5 == 0) n[BITS-1] = 1'b1;
         m = (k % 7 == 3) ? '0 : rnd() % n;
         e = rnd();
         if (k % 11 == 4) e = '0;
         if (k % 13 == 6) e = '1;
         r = calc_r2(n);
         do_run(n, r, m, e, (k % 10 == 0), res);
         chk("rand_result", res, powmod(m, e, n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               nassert, nfail);
      $finish;
   end

endmodule
